// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared width helpers and lane-slicing utility for the multi-word FIFO.
//   cnt_w(n)             : bits needed to hold a count 0..n  ($clog2(n+1))
//   addr_w(n)            : pointer width for an n-entry array (min 1)
//   get_lane(bus, k, dw) : word k of a packed multi-word bus, lane 0 at LSBs,
//                          returned zero-extended to LANE_BUS_MAX bits; the
//                          caller narrows the result to its word width.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  // Widest packed lane bus the slicing helper accepts (MAX_WR*DATA_WIDTH).
  localparam int unsigned LANE_BUS_MAX = 1024;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [LANE_BUS_MAX-1:0] get_lane(
    input logic [LANE_BUS_MAX-1:0] bus,
    input int unsigned             k,
    input int unsigned             dw
  );
    logic [LANE_BUS_MAX-1:0] mask;
    mask = ~({LANE_BUS_MAX{1'b1}} << dw);
    return (bus >> (k * dw)) & mask;
  endfunction

endpackage

// File: rtl/sync_multiword_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_multiword_fifo_mem
// FIFO_DEPTH x DATA_WIDTH register array with MAX_WR write lanes and MAX_RD
// combinational read lanes. All lane addresses wrap modulo FIFO_DEPTH.
// Storage has no reset; only pointers/occupancy in the parent are reset.
// Ports:
//   clk       in   clock, rising edge
//   wr_en     in   commit this cycle's write (already qualified by the parent)
//   wr_count  in   number of lanes to store, lane 0 first
//   wr_ptr    in   address of lane 0 of the write
//   wr_data   in   packed write lanes, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_ptr    in   address of the head word
//   rd_data   out  packed read lanes, lane k = mem[rd_ptr+k]
// -----------------------------------------------------------------------------
module sync_multiword_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_WR     = 4,
  parameter int unsigned MAX_RD     = 4,
  parameter int unsigned ADDR_WIDTH = addr_w(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [cnt_w(MAX_WR)-1:0]     wr_count,
  input  logic [ADDR_WIDTH-1:0]        wr_ptr,
  input  logic [MAX_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]        rd_ptr,
  output logic [MAX_RD*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem     [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wr_lane [MAX_WR];

  for (genvar k = 0; k < MAX_WR; k++) begin : g_wr_lane
    assign wr_lane[k] = DATA_WIDTH'(get_lane(LANE_BUS_MAX'(wr_data), k, DATA_WIDTH));
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < MAX_WR; k++) begin
      if (wr_en && (k < 32'(wr_count))) begin
        mem[ADDR_WIDTH'(32'(wr_ptr) + k)] <= wr_lane[k];
      end
    end
  end

  // First-word-fall-through: head lanes are a pure decode of rd_ptr.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < MAX_RD; k++) begin
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[ADDR_WIDTH'(32'(rd_ptr) + k)];
    end
  end

endmodule

// File: rtl/sync_multiword_fifo.sv
// -----------------------------------------------------------------------------
// sync_multiword_fifo
// Synchronous FIFO moving 0..MAX_WR words in and 0..MAX_RD words out per
// cycle, with first-word-fall-through head lanes and exact occupancy/free
// counts. A request is accepted only if it fits entirely (write vs. free
// space, read vs. stored words, both judged on pre-cycle occupancy); a
// rejected request leaves state untouched while the other direction proceeds.
// Optional sticky error flags are built when FIFO_ERR_FLAGS_EN is defined.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   FIFO_wr_en          write request
//   FIFO_wr_count       words in this write, lane 0 first
//   FIFO_wr_data        packed write lanes
//   FIFO_rd_en          read request
//   FIFO_rd_count       words popped this cycle
//   FIFO_rd_data        packed head lanes; lane k valid when k < occupancy
//   FIFO_full/empty     occupancy == FIFO_DEPTH / == 0
//   FIFO_almost_full    occupancy >= AF_LEVEL
//   FIFO_almost_empty   occupancy <= AE_LEVEL
//   FIFO_available      free words
//   FIFO_occupancy      stored words
//   FIFO_overflow       sticky rejected-write flag (FIFO_ERR_FLAGS_EN only)
//   FIFO_underflow      sticky rejected-read flag  (FIFO_ERR_FLAGS_EN only)
// -----------------------------------------------------------------------------
module sync_multiword_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_WR     = 4,
  parameter int unsigned MAX_RD     = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         FIFO_wr_en,
  input  logic [cnt_w(MAX_WR)-1:0]     FIFO_wr_count,
  input  logic [MAX_WR*DATA_WIDTH-1:0] FIFO_wr_data,
  input  logic                         FIFO_rd_en,
  input  logic [cnt_w(MAX_RD)-1:0]     FIFO_rd_count,
  output logic [MAX_RD*DATA_WIDTH-1:0] FIFO_rd_data,
  output logic                         FIFO_full,
  output logic                         FIFO_empty,
  output logic                         FIFO_almost_full,
  output logic                         FIFO_almost_empty,
  output logic [ADDR_WIDTH:0]          FIFO_available,
  output logic [ADDR_WIDTH:0]          FIFO_occupancy
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                         FIFO_overflow,
  output logic                         FIFO_underflow
`endif
);

  localparam int unsigned       OCC_W   = ADDR_WIDTH + 1;
  localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]  AF_C    = OCC_W'(AF_LEVEL);
  localparam logic [OCC_W-1:0]  AE_C    = OCC_W'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W-1:0]      available;
  logic [OCC_W-1:0]      wr_amt;
  logic [OCC_W-1:0]      rd_amt;
  logic                  wr_accept;
  logic                  rd_accept;

  assign available = DEPTH_C - occupancy;

  // Acceptance uses only registered occupancy, so space freed by a same-cycle
  // read is never handed to a same-cycle write.
  always_comb begin
    wr_accept = FIFO_wr_en && (OCC_W'(FIFO_wr_count) <= available);
    rd_accept = FIFO_rd_en && (OCC_W'(FIFO_rd_count) <= occupancy);
    wr_amt    = wr_accept ? OCC_W'(FIFO_wr_count) : '0;
    rd_amt    = rd_accept ? OCC_W'(FIFO_rd_count) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_ptr    <= wr_ptr + ADDR_WIDTH'(wr_amt);
      rd_ptr    <= rd_ptr + ADDR_WIDTH'(rd_amt);
      occupancy <= occupancy + wr_amt - rd_amt;
    end
  end

  // Status is decoded from the occupancy register only.
  always_comb begin
    FIFO_full         = (occupancy == DEPTH_C);
    FIFO_empty        = (occupancy == '0);
    FIFO_almost_full  = (occupancy >= AF_C);
    FIFO_almost_empty = (occupancy <= AE_C);
    FIFO_available    = available;
    FIFO_occupancy    = occupancy;
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      FIFO_overflow  <= 1'b0;
      FIFO_underflow <= 1'b0;
    end else begin
      if (FIFO_wr_en && !wr_accept) FIFO_overflow  <= 1'b1;
      if (FIFO_rd_en && !rd_accept) FIFO_underflow <= 1'b1;
    end
  end
`endif

  // Writes during reset must not land in storage either, so gate with rst.
  sync_multiword_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_WR     (MAX_WR),
    .MAX_RD     (MAX_RD),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .wr_en    (wr_accept && !rst),
    .wr_count (FIFO_wr_count),
    .wr_ptr   (wr_ptr),
    .wr_data  (FIFO_wr_data),
    .rd_ptr   (rd_ptr),
    .rd_data  (FIFO_rd_data)
  );

endmodule

// File: tb/tb_sync_multiword_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_multiword_fifo
// Directed scoreboard bench for sync_multiword_fifo (DEPTH=16, 4x32 lanes,
// AF=12, AE=2). The driver tracks expected occupancy/flags and queues every
// accepted write word; a monitor pops and compares words whenever the DUT
// performs a read. Error-flag checks follow FIFO_ERR_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_sync_multiword_fifo;

  localparam int DW = 32;
  localparam int D  = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [2:0]   wr_count;
  logic [127:0] wr_data;
  logic         rd_en;
  logic [2:0]   rd_count;
  logic [127:0] rd_data;
  logic         full, empty, afull, aempty;
  logic [4:0]   avail, occ;
`ifdef FIFO_ERR_FLAGS_EN
  logic         ovf, unf;
`endif

  always #5 clk = ~clk;

  sync_multiword_fifo #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (16),
    .MAX_WR     (4),
    .MAX_RD     (4),
    .AF_LEVEL   (12),
    .AE_LEVEL   (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .FIFO_wr_en        (wr_en),
    .FIFO_wr_count     (wr_count),
    .FIFO_wr_data      (wr_data),
    .FIFO_rd_en        (rd_en),
    .FIFO_rd_count     (rd_count),
    .FIFO_rd_data      (rd_data),
    .FIFO_full         (full),
    .FIFO_empty        (empty),
    .FIFO_almost_full  (afull),
    .FIFO_almost_empty (aempty),
    .FIFO_available    (avail),
    .FIFO_occupancy    (occ)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .FIFO_overflow     (ovf),
    .FIFO_underflow    (unf)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          m_occ = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk4(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Monitor: in the middle of each cycle, any read the DUT will perform at
  // the next edge must present the queued words on lanes 0..rd_count-1.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && rd_en === 1'b1 && rd_count != 3'd0 &&
          32'(rd_count) <= 32'(occ)) begin
        for (int k = 0; k < int'(rd_count); k++) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_lane%0d: got %h expected none queued", k, rd_data[k*DW +: DW]);
          end else begin
            logic [31:0] w;
            w = exp_q.pop_front();
            chk($sformatf("rd_lane%0d", k), rd_data[k*DW +: DW], w);
          end
        end
      end
    end
  end

  // Drive one cycle (inputs set just after a rising edge) and advance the model.
  task automatic drive(input bit r, input bit we, input int wc, input logic [127:0] wd,
                       input bit re, input int rc);
    int  nocc;
    bit  wok, rok;
    rst      = r;
    wr_en    = we;
    wr_count = 3'(wc);
    wr_data  = wd;
    rd_en    = re;
    rd_count = 3'(rc);
    if (r) begin
      nocc = 0;
      m_ovf = 0;
      m_unf = 0;
      exp_q.delete();
    end else begin
      wok = we && (wc <= D - m_occ);
      rok = re && (rc <= m_occ);
      if (we && !wok) m_ovf = 1;
      if (re && !rok) m_unf = 1;
      if (wok) for (int k = 0; k < wc; k++) exp_q.push_back(wd[k*DW +: DW]);
      nocc = m_occ + (wok ? wc : 0) - (rok ? rc : 0);
    end
    @(posedge clk);
    #1;
    m_occ = nocc;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_status(input string name);
    chk({name, "_occ"},    32'(occ),    32'(m_occ));
    chk({name, "_avail"},  32'(avail),  32'(D - m_occ));
    chk({name, "_empty"},  32'(empty),  32'(m_occ == 0));
    chk({name, "_full"},   32'(full),   32'(m_occ == D));
    chk({name, "_aempty"}, 32'(aempty), 32'(m_occ <= 2));
    chk({name, "_afull"},  32'(afull),  32'(m_occ >= 12));
`ifdef FIFO_ERR_FLAGS_EN
    chk({name, "_ovf"},    32'(ovf),    32'(m_ovf));
    chk({name, "_unf"},    32'(unf),    32'(m_unf));
`endif
    for (int k = 0; k < 4 && k < m_occ; k++)
      chk($sformatf("%s_head%0d", name, k), rd_data[k*DW +: DW], exp_q[k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_count = '0; wr_data = '0; rd_en = 1'b0; rd_count = '0;

    // Reset with traffic present.
    drive(1, 1, 4, mk4(32'hEEEE_0000), 1, 1);
    drive(1, 0, 0, '0, 0, 0);
    check_status("reset");

    // 1: one 4-word write, head lanes show it immediately.
    drive(0, 1, 4, mk4(32'hA000_0000), 0, 0);
    check_status("t1");

    // 2: fill to 16, then a 1-word write is rejected.
    drive(0, 1, 4, mk4(32'hB000_0000), 0, 0);
    drive(0, 1, 4, mk4(32'hC000_0000), 0, 0);
    drive(0, 1, 4, mk4(32'hD000_0000), 0, 0);
    check_status("t2_full");
    drive(0, 1, 1, mk4(32'hE000_0000), 0, 0);
    check_status("t2_reject");

    // Zero-count requests are legal no-ops.
    drive(0, 1, 0, mk4(32'hF000_0000), 1, 0);
    check_status("zero_cnt");

    // 3: down to 14, then write 3 (rejected) with read 2 (accepted) -> 12.
    drive(0, 0, 0, '0, 1, 2);
    check_status("t3_pre");
    drive(0, 1, 3, mk4(32'h3000_0000), 1, 2);
    check_status("t3");

    // Drain.
    drive(0, 0, 0, '0, 1, 4);
    drive(0, 0, 0, '0, 1, 4);
    drive(0, 0, 0, '0, 1, 4);
    check_status("drain");

    // 4: pointer wrap after 15 single-word push/pops.
    drive(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 1, {96'b0, 32'h4000_0000 + 32'(i)}, 0, 0);
      drive(0, 0, 0, '0, 1, 1);
    end
    check_status("t4_pre");
    drive(0, 1, 4, mk4(32'h5000_0000), 0, 0);
    check_status("t4_wrap");
    drive(0, 0, 0, '0, 1, 4);
    check_status("t4_read");

    // 5: read from empty FIFO.
    drive(0, 0, 0, '0, 1, 1);
    check_status("t5");

    // Almost-empty boundary 2 -> 3.
    drive(0, 1, 2, mk4(32'h6000_0000), 0, 0);
    check_status("ae_2");
    drive(0, 1, 1, mk4(32'h6100_0000), 0, 0);
    check_status("ae_3");

    // 6: occupancy 9 then reset with traffic.
    drive(0, 1, 4, mk4(32'h7000_0000), 0, 0);
    drive(0, 1, 2, mk4(32'h7100_0000), 0, 0);
    check_status("t6_pre");
    drive(1, 1, 4, mk4(32'h7200_0000), 1, 2);
    check_status("t6");

    // Fresh data after reset is stored from address 0 and read back.
    drive(0, 1, 3, mk4(32'h8000_0000), 0, 0);
    drive(0, 0, 0, '0, 1, 3);
    check_status("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
